parity_tx_ctrl: RTL and testbench

Frame-sequencing controller for the parity generator datapath. It accepts a parallel word over a valid/ready handshake and serialises it LSB-first as start bit, data bits, parity bit and stop bit. The parity bit is accumulated bit-by-bit as the data shifts out, and the block paces each bit with a bit-period counter. It sits between a word producer and a serial line driver.

---
 rtl/parity_tx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_parity_tx_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_tx_ctrl.sv
// parity_tx_ctrl: frame sequencer for the parity generator datapath.
// Accepts a word over valid/ready, then drives start bit, DATA_W data bits
// (LSB first), parity bit and stop bit on ser_out, each CLKS_PER_BIT cycles.
module parity_tx_ctrl #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned ODD          = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              busy,
    output logic              done,
    output logic              parity_out
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);
    localparam logic             ODD_BIT     = (ODD != 0);
    localparam logic             ONE_CLK_BIT = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic               acc_q;
    logic [BIT_W-1:0]   bit_q;
    logic [CNT_W-1:0]   period_q;
    logic               ser_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               parity_q;

    logic [DATA_W-1:0]  shift_d;
    logic               acc_d;
    logic [CNT_W-1:0]   period_d;
    logic [BIT_W-1:0]   bit_d;
    logic               period_end_c;
    logic               last_bit_c;
    logic               stop_last_next_c;

    // Per-cycle helpers: next shift/accumulator/counter values and bit-boundary flags
    always_comb begin
        shift_d          = shift_q >> 1;
        acc_d            = acc_q ^ shift_q[0];
        period_d         = period_q + CNT_W'(1);
        bit_d            = bit_q + BIT_W'(1);
        period_end_c     = (period_q == PERIOD_LAST);
        last_bit_c       = (bit_q == BIT_LAST);
        stop_last_next_c = (period_d == PERIOD_LAST);
    end

    // Frame FSM; every output register is loaded with the value for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            acc_q    <= 1'b0;
            bit_q    <= '0;
            period_q <= '0;
            ser_q    <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && ready_q) begin
                        shift_q  <= in_data;
                        acc_q    <= ODD_BIT;
                        bit_q    <= '0;
                        period_q <= '0;
                        ser_q    <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end

                S_START: begin
                    if (period_end_c) begin
                        period_q <= '0;
                        ser_q    <= shift_q[0];
                        state_q  <= S_DATA;
                    end else begin
                        period_q <= period_d;
                    end
                end

                S_DATA: begin
                    if (period_end_c) begin
                        period_q <= '0;
                        acc_q    <= acc_d;
                        shift_q  <= shift_d;
                        bit_q    <= bit_d;
                        if (last_bit_c) begin
                            // Accumulator is complete once the last data bit is folded in
                            ser_q    <= acc_d;
                            parity_q <= acc_d;
                            state_q  <= S_PARITY;
                            done_q   <= 1'b0;
                        end else begin
                            ser_q <= shift_d[0];
                        end
                    end else begin
                        period_q <= period_d;
                    end
                end

                S_PARITY: begin
                    if (period_end_c) begin
                        period_q <= '0;
                        ser_q    <= 1'b1;
                        state_q  <= S_STOP;
                        // Single-cycle bits make the first STOP cycle also the last
                        done_q   <= ONE_CLK_BIT;
                    end else begin
                        period_q <= period_d;
                    end
                end

                S_STOP: begin
                    if (period_end_c) begin
                        period_q <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        period_q <= period_d;
                        done_q   <= stop_last_next_c;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    period_q <= '0;
                    ser_q    <= 1'b1;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign ser_out    = ser_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign parity_out = parity_q;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Scoreboard bench for parity_tx_ctrl: three instances (8b/4clk even,
// 8b/4clk odd, 3b/1clk even); stimulus pushes expected words+parity,
// a negedge monitor reconstructs each frame and compares on done.
module tb_parity_tx_ctrl;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NDUT-1:0] vld;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] ser;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;
    logic [NDUT-1:0] pout;
    logic [7:0]      din_a;
    logic [7:0]      din_b;
    logic [2:0]      din_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    int  exp_done [NDUT];
    int  got_done [NDUT];
    int  cap_len  [NDUT];
    bit  cap      [NDUT][64];
    bit  rdy_viol [NDUT];

    parity_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din_a),
        .ser_out(ser[0]), .busy(busy[0]), .done(done[0]), .parity_out(pout[0]));
    parity_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din_b),
        .ser_out(ser[1]), .busy(busy[1]), .done(done[1]), .parity_out(pout[1]));
    parity_tx_ctrl #(.DATA_W(3), .CLKS_PER_BIT(1), .ODD(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(din_c),
        .ser_out(ser[2]), .busy(busy[2]), .done(done[2]), .parity_out(pout[2]));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dw(input int i);
        return (i == 2) ? 3 : 8;
    endfunction

    function automatic int cpb(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int i, input logic [8:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        exp_done[i]++;
    endtask

    task automatic pop_exp(input int i, output logic [8:0] e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Compare a captured frame against the expected word and parity
    task automatic check_frame(input int i);
        logic [8:0] e;
        int w;
        int c;
        int flen;
        int mism;
        int b;
        bit ev;
        w = dw(i);
        c = cpb(i);
        flen = (w + 3) * c;
        if (qsize(i) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done dut%0d: got done expected none", i);
            return;
        end
        pop_exp(i, e);
        check($sformatf("frame_len dut%0d word=%0h", i, e[7:0]), 32'(cap_len[i]), 32'(flen));
        mism = 0;
        for (int k = 0; k < flen; k++) begin
            b = k / c;
            if (b == 0)          ev = 1'b0;
            else if (b <= w)     ev = e[b-1];
            else if (b == w + 1) ev = e[8];
            else                 ev = 1'b1;
            if (k >= cap_len[i] || k >= 64 || cap[i][k] != ev) mism++;
        end
        check($sformatf("serial dut%0d word=%0h", i, e[7:0]), 32'(mism), 32'd0);
        check($sformatf("parity_out dut%0d word=%0h", i, e[7:0]), 32'(pout[i]), 32'(e[8]));
        check($sformatf("ready_low dut%0d word=%0h", i, e[7:0]), 32'(rdy_viol[i]), 32'd0);
    endtask

    // Monitor: capture ser_out while busy, score the frame on done
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                cap_len[i]  = 0;
                rdy_viol[i] = 1'b0;
            end else begin
                if (busy[i]) begin
                    if (cap_len[i] < 64) cap[i][cap_len[i]] = ser[i];
                    cap_len[i]++;
                    if (rdy[i]) rdy_viol[i] = 1'b1;
                end
                if (done[i]) begin
                    got_done[i]++;
                    check_frame(i);
                    cap_len[i]  = 0;
                    rdy_viol[i] = 1'b0;
                end else if (!busy[i] && cap_len[i] != 0) begin
                    cap_len[i]  = 0;
                    rdy_viol[i] = 1'b0;
                end
            end
        end
    end

    task automatic set_data(input int i, input logic [7:0] d);
        case (i)
            0:       din_a = d;
            1:       din_b = d;
            default: din_c = d[2:0];
        endcase
    endtask

    // Offer a word and return the cycle stamp of the accepting edge
    task automatic send(input int i, input logic [7:0] d, input logic par,
                        input bit push, input bit keep, output int acc_cyc);
        int n;
        @(negedge clk);
        set_data(i, d);
        vld[i] = 1'b1;
        n = 0;
        while (!rdy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[i]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed 0 expected 1", i);
            vld[i] = 1'b0;
            acc_cyc = -1;
            return;
        end
        if (push) push_exp(i, {par, d});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) vld[i] = 1'b0;
    endtask

    // Wait for done; n is the cycle index (1 = first cycle after the call)
    task automatic wait_done(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < 500);
        if (!done[i]) begin
            total++;
            bad++;
            $display("FAIL done_timeout dut%0d: done stayed 0 expected 1", i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int n;
        logic [7:0] ptab;
        ptab = 8'b1001_0110;
        for (int i = 0; i < NDUT; i++) begin
            exp_done[i] = 0;
            got_done[i] = 0;
            cap_len[i]  = 0;
            rdy_viol[i] = 1'b0;
        end
        vld   = '0;
        din_a = '0;
        din_b = '0;
        din_c = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("reset_state dut%0d", i),
                  32'({ser[i], rdy[i], busy[i], done[i], pout[i]}), 32'b11000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 0xA5, even parity: done on the 44th cycle after acceptance
        send(0, 8'hA5, 1'b0, 1'b1, 1'b0, a1);
        wait_done(0, n);
        check("a5_done_cycle", 32'(n), 32'd44);

        // Back-to-back with in_valid held: next acceptance one cycle after done
        send(0, 8'h07, 1'b1, 1'b1, 1'b1, a1);
        send(0, 8'h00, 1'b0, 1'b1, 1'b0, a2);
        check("b2b_accept_gap", 32'(a2 - a1), 32'd45);
        wait_done(0, n);

        // Odd parity instance
        send(1, 8'hFF, 1'b1, 1'b1, 1'b0, a1);
        wait_done(1, n);
        send(1, 8'hFE, 1'b0, 1'b1, 1'b0, a1);
        wait_done(1, n);

        // 3-bit words at one clock per bit: six-cycle frames
        for (int w = 0; w < 8; w++) begin
            send(2, 8'(w), ptab[w], 1'b1, 1'b0, a1);
            wait_done(2, n);
            check($sformatf("c_frame_cycles w=%0d", w), 32'(n), 32'd6);
        end

        // Input activity while busy must not disturb the frame in flight
        send(0, 8'h3E, 1'b1, 1'b1, 1'b0, a1);
        repeat (20) begin
            @(negedge clk);
            vld[0] = 1'($urandom_range(0, 1));
            din_a  = 8'($urandom);
        end
        vld[0] = 1'b0;
        wait_done(0, n);
        @(negedge clk);
        @(negedge clk);
        check("no_second_accept", 32'(busy[0]), 32'd0);

        // Reset two cycles into DATA aborts the frame without a clock
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0, a1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs",
              32'({ser[0], rdy[0], busy[0], done[0], pout[0]}), 32'b11000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h01, 1'b1, 1'b1, 1'b0, a1);
        wait_done(0, n);
        repeat (3) @(negedge clk);

        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("done_count dut%0d", i), 32'(got_done[i]), 32'(exp_done[i]));
            check($sformatf("queue_empty dut%0d", i), 32'(qsize(i)), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
